// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock, gap-free when words arrive back-to-back.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             at_last;
    logic             accept;

    // Ready depends only on state so no path exists from din_valid to din_ready.
    assign at_last   = (state == SHIFT) && (cnt == LAST);
    assign din_ready = (state == IDLE) || at_last;
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!at_last) begin
                        if (MSB_FIRST)
                            sreg <= {sreg[WIDTH-2:0], 1'b0};
                        else
                            sreg <= {1'b0, sreg[WIDTH-1:1]};
                        cnt <= cnt + 1'b1;
                    end else if (accept) begin
                        // Reload in the last-bit cycle keeps the stream gap-free.
                        sreg <= din;
                        cnt  <= '0;
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign sout       = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;
    assign sout_valid = (state == SHIFT);
    assign sout_last  = at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus a randomized
// run compared against a bits-remaining reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] a_din = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_sout, a_sv, a_last;

    logic [3:0] b_din = '0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_sout, b_sv, b_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
        .sout(a_sout), .sout_valid(a_sv), .sout_last(a_last)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
        .sout(b_sout), .sout_valid(b_sv), .sout_last(b_last)
    );

    function automatic logic bit_of(input logic [31:0] w, input int idx, input int width, input bit msb);
        return msb ? w[width-1-idx] : w[idx];
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        a_valid = 1'b1;
        a_din = 8'hFF;
        b_valid = 1'b1;
        b_din = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({a_sout, a_sv, a_last, a_ready} !== 4'b0001) begin
                errors++;
                $display("FAIL reset_a cyc%0d: got sout/sv/last/rdy=%b want 0001", i, {a_sout, a_sv, a_last, a_ready});
            end
            checks++;
            if ({b_sout, b_sv, b_last, b_ready} !== 4'b0001) begin
                errors++;
                $display("FAIL reset_b cyc%0d: got %b want 0001", i, {b_sout, b_sv, b_last, b_ready});
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_sout, a_sv, a_last, a_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: got %b want 0001", {a_sout, a_sv, a_last, a_ready});
        end
    endtask

    task automatic test_single_msb();
        logic [7:0] w = 8'hA5;
        @(negedge clk);
        a_din = w;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        a_din = 8'h00;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({a_sout, a_sv, a_last, a_ready} !== {w[7-k], 1'b1, k == 7, k == 7}) begin
                errors++;
                $display("FAIL single_msb bit%0d: got sout/sv/last/rdy=%b want %b", k,
                         {a_sout, a_sv, a_last, a_ready}, {w[7-k], 1'b1, k == 7, k == 7});
            end
            @(negedge clk);
        end
        checks++;
        if ({a_sout, a_sv, a_last, a_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL single_msb_idle: got %b want 0001", {a_sout, a_sv, a_last, a_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream = 16'b1010101001010101;
        @(negedge clk);
        a_din = 8'hAA;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_din = 8'h55;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({a_sout, a_sv, a_last, a_ready} !== {stream[15-i], 1'b1, (i % 8) == 7, (i % 8) == 7}) begin
                errors++;
                $display("FAIL back_to_back bit%0d: got sout/sv/last/rdy=%b want %b", i,
                         {a_sout, a_sv, a_last, a_ready}, {stream[15-i], 1'b1, (i % 8) == 7, (i % 8) == 7});
            end
            if (i == 15) a_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({a_sv, a_sout} !== 2'b00) begin
            errors++;
            $display("FAIL back_to_back_idle: got sv/sout=%b want 00", {a_sv, a_sout});
        end
    endtask

    task automatic test_lsb_w4();
        logic [3:0] w = 4'b0011;
        @(negedge clk);
        b_din = w;
        b_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        b_din = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({b_sout, b_sv, b_last, b_ready} !== {w[k], 1'b1, k == 3, k == 3}) begin
                errors++;
                $display("FAIL lsb_w4 bit%0d: got sout/sv/last/rdy=%b want %b", k,
                         {b_sout, b_sv, b_last, b_ready}, {w[k], 1'b1, k == 3, k == 3});
            end
            @(negedge clk);
        end
        checks++;
        if ({b_sout, b_sv, b_ready} !== 3'b001) begin
            errors++;
            $display("FAIL lsb_w4_idle: got sout/sv/rdy=%b want 001", {b_sout, b_sv, b_ready});
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w = 8'hF0;
        logic [7:0] nxt = 8'h3C;
        @(negedge clk);
        a_din = w;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({a_sout, a_sv} !== {w[7-k], 1'b1}) begin
                errors++;
                $display("FAIL midrst_pre bit%0d: got sout/sv=%b want %b", k, {a_sout, a_sv}, {w[7-k], 1'b1});
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({a_sout, a_sv, a_last, a_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_async: got %b want 0001", {a_sout, a_sv, a_last, a_ready});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({a_sout, a_sv} !== 2'b00) begin
                errors++;
                $display("FAIL midrst_after cyc%0d: got sout/sv=%b want 00", i, {a_sout, a_sv});
            end
        end
        a_din = nxt;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({a_sout, a_sv, a_last} !== {nxt[7-k], 1'b1, k == 7}) begin
                errors++;
                $display("FAIL midrst_next bit%0d: got sout/sv/last=%b want %b", k,
                         {a_sout, a_sv, a_last}, {nxt[7-k], 1'b1, k == 7});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_detector_chain();
        logic [3:0] hist = 4'b0000;
        int bitno = 0;
        int pulses[$];
        int idle_pulses = 0;
        int want[4] = '{4, 6, 8, 16};
        @(negedge clk);
        a_din = 8'hAA;
        a_valid = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) a_din = 8'h0A;
            if (c == 8) a_valid = 1'b0;
            hist = {hist[2:0], a_sout};
            if (a_sv) bitno++;
            if (hist == 4'b1010) begin
                if (a_sv) pulses.push_back(bitno);
                else idle_pulses++;
            end
        end
        checks++;
        if (pulses.size() != 4 || idle_pulses != 0) begin
            errors++;
            $display("FAIL detector_count: got %0d pulses (%0d idle) want 4 (0 idle)", pulses.size(), idle_pulses);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < pulses.size()) begin
                checks++;
                if (pulses[i] != want[i]) begin
                    errors++;
                    $display("FAIL detector_pos%0d: got bit %0d want bit %0d", i, pulses[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int         rem = 0;
        logic [7:0] word = '0;
        logic       hold = 1'b0;
        logic       accept;
        logic [3:0] got, want;
        @(negedge clk);
        for (int c = 0; c < 400; c++) begin
            want = {rem > 0 ? bit_of(32'(word), 8 - rem, 8, 1'b1) : 1'b0, rem > 0, rem == 1, rem <= 1};
            got  = {a_sout, a_sv, a_last, a_ready};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random cyc%0d: got sout/sv/last/rdy=%b want %b", c, got, want);
            end
            if (!hold) begin
                a_valid = (c < 380) && ($urandom_range(0, 3) != 0);
                a_din = 8'($urandom);
            end
            accept = a_valid && (rem <= 1);
            @(posedge clk);
            if (accept) begin
                word = a_din;
                rem = 8;
            end else if (rem > 0) begin
                rem--;
            end
            hold = a_valid && !accept;
            @(negedge clk);
        end
        a_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_msb();
        test_back_to_back();
        test_lsb_w4();
        test_reset_mid_word();
        test_detector_chain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of the serial sequence detectors in the FSM group (e.g. the overlapping 1010 Mealy detector). It accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock onto a single serial line. Back-to-back words produce a gap-free bit stream. When no word is in flight, the line holds a fixed idle level, so a detector that samples every clock sees no spurious data.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first
- IDLE_BIT, 0, level driven on sout while no word is being shifted

- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- din  input  WIDTH  parallel word; sampled only on an accept edge
- din_valid  input  1  upstream has a word on din
- din_ready  output  1  block can accept a word this cycle
- sout  output  WIDTH=1  serial data bit; feeds the detector's `in`
- sout_valid  output  1  sout carries a data bit this cycle
- sout_last  output  1  sout carries the final bit of the current word

## Operation
- FSM states: IDLE, SHIFT. Internal registers:
  - shift register sreg[WIDTH-1:0]
  - bit counter cnt, width $clog2(WIDTH), counting 0..WIDTH-1
- Accept event: din_valid && din_ready at a rising edge.
- din_ready is combinational from state only, never from din_valid:
  - 1 in IDLE
  - 1 in SHIFT when cnt == WIDTH-1
  - 0 otherwise
- IDLE:
  - On accept: load sreg <= din, cnt <= 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each edge with cnt < WIDTH-1: shift sreg toward the output end and increment cnt.
    - MSB_FIRST=1: shift left.
    - MSB_FIRST=0: shift right.
  - Edge with cnt == WIDTH-1 and an accept: reload sreg <= din, cnt <= 0, stay in SHIFT. This is the no-gap path.
  - Edge with cnt == WIDTH-1 and no accept: go to IDLE.
- Outputs are registered values or decoded directly from registers; there is no combinational path from din or din_valid to any output.
  - sout = sreg[WIDTH-1] when MSB_FIRST=1, sreg[0] when MSB_FIRST=0, valid only in SHIFT; IDLE_BIT in IDLE.
  - sout_valid = (state == SHIFT).
  - sout_last = (state == SHIFT) && (cnt == WIDTH-1).
- din is ignored on every edge that is not an accept edge.
- din_valid asserted while din_ready = 0 is legal. Upstream must hold din stable until accepted; the block never drops or partially loads a word.

## Timing
- Reset (rst low), immediately and asynchronously:
  - state = IDLE, cnt = 0, sreg = 0
  - sout = IDLE_BIT, sout_valid = 0, sout_last = 0, din_ready = 1
- Reset release: the first accept can occur on the first rising edge after rst goes high.
- Latency: a word accepted at edge N drives its first bit in the cycle after edge N. Bit k appears in cycle N+1+k. sout_last is high in cycle N+WIDTH.
- Throughput: one bit per clock. Continuous din_valid gives 100% sout_valid duty with no idle cycles between words.
- Single word with no follow-on: sout returns to IDLE_BIT in cycle N+WIDTH+1.
- Reset mid-word: the in-flight word is discarded; no further bits of it appear after release.
- din_valid dropping in the last-bit cycle: no accept, so the block goes to IDLE.

## Test plan
- Reset: hold rst low with din_valid=1, din=8'hFF -> sout=0, sout_valid=0, sout_last=0, din_ready=1; no accept occurs while rst is low.
- Single word, MSB_FIRST=1: din=8'hA5 accepted at edge N -> sout = 1,0,1,0,0,1,0,1 in cycles N+1..N+8; sout_last only in cycle N+8; sout=0 with sout_valid=0 in cycle N+9.
- Back-to-back: din_valid held high with 8'hAA then 8'h55 -> 16 consecutive valid bits 1010101001010101; din_ready high only in IDLE and in each last-bit cycle; the second word is accepted in the first word's last-bit cycle.
- LSB-first, WIDTH=4: din=4'b0011 accepted -> sout = 1,1,0,0; din_ready low for the three middle bit cycles.
- Reset mid-word: 8'hF0 accepted, rst pulsed low after the third bit -> outputs return to reset values immediately; no remaining bits of 8'hF0 appear after release; the next word serializes from its first bit.
- Chain with the 1010 detector: words 8'hAA, 8'h0A sent back-to-back into the detector's `in` -> detector out pulses on the 4th, 6th, 8th and 16th bits (overlapping detection); no pulses while the line is idle.
